ysyx_24100012_mem_responder: RTL and testbench
==============================================

// Module: ysyx_24100012_mem_responder
// PURPOSE
//  Memory-side responder for the core's fetch/load-store request interface.
//  Accepts one read or write request via valid/ready and returns a response
//  after a programmable latency. Backs a word-organised RAM at ORIGIN_ADDR.
//  Replaces the core's zero-latency combinational RAM so IFU/LSU initiators
//  can be built and verified against a multi-cycle handshake.
// PARAMETERS
//  ADDR_WIDTH   32            address bus width
//  DATA_WIDTH   32            data bus width; must be a multiple of 8
//  ORIGIN_ADDR  32'h80000000  byte address of word 0
//  MEM_SIZE     4096          capacity in bytes; multiple of DATA_WIDTH/8
//  LATENCY      1             cycles from request accept to rsp_valid; >=1
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             reset, asynchronous, active-low (0 = reset)
//  req_valid  in   1             initiator presents a request
//  req_ready  out  1             responder can accept a request
//  req_wen    in   1             1 = write, 0 = read
//  req_addr   in   ADDR_WIDTH    byte address
//  req_wdata  in   DATA_WIDTH    write data
//  req_wstrb  in   DATA_WIDTH/8  byte-lane write enables
//  rsp_valid  out  1             response valid
//  rsp_ready  in   1             initiator accepts response
//  rsp_rdata  out  DATA_WIDTH    read data (0 for writes and errors)
//  rsp_err    out  1             1 = address outside [ORIGIN_ADDR, +MEM_SIZE)
// BEHAVIOUR
//  - States: IDLE, WAIT, RESP. req_ready = (state==IDLE) && rst.
//  - Reset (rst=0, async): state=IDLE, req_ready=0, rsp_valid=0,
//    rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents not cleared.
//  - Accept: req_valid && req_ready at edge N. On that edge: latch request;
//    word index = (req_addr-ORIGIN_ADDR) >> log2(DATA_WIDTH/8); low address
//    bits ignored (aligned down). In-range write: update lanes with
//    req_wstrb=1 only. In-range read: capture word into rsp_rdata reg.
//    Out of range: no RAM access, rsp_err=1, rsp_rdata=0.
//  - LATENCY==1: IDLE->RESP at edge N; rsp_valid=1 from cycle N+1.
//    LATENCY>1: IDLE->WAIT, counter=LATENCY-1, decrement each edge;
//    WAIT->RESP on edge where counter==1; rsp_valid high LATENCY cycles
//    after accept edge.
//  - RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready=1;
//    on handshake edge -> IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  - No overlap: req_ready=0 in WAIT and RESP even if rsp_ready=1; max
//    throughput one transaction per LATENCY+1 cycles.
//  - req_valid in WAIT/RESP ignored (initiator must hold it; not consumed).
//  - Write then read of same word: read returns new data (write committed
//    at its accept edge).
//  - Range check uses full-width compare; addr = ORIGIN_ADDR+MEM_SIZE-1 is in
//    range, ORIGIN_ADDR+MEM_SIZE and ORIGIN_ADDR-1 are errors, no wrap.
//  - Reset mid-transaction: transaction dropped, no response issued; a write
//    already accepted stays in RAM.
// TESTING
//  1 LATENCY=1: write 32'hDEADBEEF @80000000 wstrb=F, then read same ->
//    rsp_valid cycle after each accept, rdata=DEADBEEF, err=0.
//  2 Byte strobes: write 11223344 then AABBCCDD wstrb=4'b0101 @80000010,
//    read -> 11BB33DD.
//  3 LATENCY=4, rsp_ready held 0 for 3 cycles: rsp_valid rises 4 cycles
//    after accept, data stable until ready, req_ready=0 throughout.
//  4 Read @80001000 (MEM_SIZE=4096) and @7FFFFFFC -> err=1, rdata=0; read
//    @80000FFC -> err=0.
//  5 Unaligned read @80000003 -> returns word @80000000.
//  6 Assert rst=0 in WAIT: outputs 0 immediately; after release req_ready=1,
//    no stale rsp_valid, earlier write data still readable.

Source files
------------

// File: rtl/ysyx_24100012_mem_responder.sv
// Word-organised RAM behind a valid/ready request/response handshake.
// Each request is answered after LATENCY cycles; out-of-range addresses return rsp_err.
module ysyx_24100012_mem_responder #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = 32'h8000_0000,
    parameter int unsigned           MEM_SIZE    = 4096,
    parameter int unsigned           LATENCY     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int unsigned LANES     = DATA_WIDTH / 8;
    localparam int unsigned DEPTH     = MEM_SIZE / LANES;
    localparam int unsigned OFF_SHIFT = $clog2(LANES);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        word_idx;
    logic                    in_range;
    logic                    accept;
    logic                    mem_we;

    // Offset-based compare avoids overflow of ORIGIN_ADDR + MEM_SIZE at the top of the map.
    assign offset   = req_addr - ORIGIN_ADDR;
    assign in_range = (req_addr >= ORIGIN_ADDR) && (offset < ADDR_WIDTH'(MEM_SIZE));
    assign word_idx = offset[OFF_SHIFT +: IDX_W];

    assign req_ready = (state_q == S_IDLE) && rst;
    assign accept    = req_valid && req_ready;
    assign mem_we    = accept && req_wen && in_range;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rsp_err_d   = !in_range;
                    rsp_rdata_d = (in_range && !req_wen) ? mem_q[word_idx] : '0;
                    if (LATENCY == 1) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (req_wstrb[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100012_mem_responder.sv
// Bench for ysyx_24100012_mem_responder: a LATENCY=1 and a LATENCY=4 instance
// checked against a byte-level memory model with directed and random transactions.
module tb_ysyx_24100012_mem_responder;

    localparam longint ORIGIN = 64'h8000_0000;
    localparam longint MSIZE  = 4096;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;
    int          sel;

    logic        ready_a, valid_a, err_a;
    logic [31:0] rdata_a;
    logic        ready_b, valid_b, err_b;
    logic [31:0] rdata_b;

    logic        ready_o, valid_o, err_o;
    logic [31:0] rdata_o;

    logic [31:0] ref_mem [2][1024];

    int checks;
    int passes;
    int fails;

    ysyx_24100012_mem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && (sel == 0)), .req_ready(ready_a),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a)
    );

    ysyx_24100012_mem_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && (sel == 1)), .req_ready(ready_b),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b)
    );

    assign ready_o = (sel == 1) ? ready_b : ready_a;
    assign valid_o = (sel == 1) ? valid_b : valid_a;
    assign err_o   = (sel == 1) ? err_b   : err_a;
    assign rdata_o = (sel == 1) ? rdata_b : rdata_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: returns expected rdata/err and commits writes byte by byte.
    task automatic model(input int d, input bit wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         output logic [31:0] exp_rdata, output logic exp_err);
        longint a;
        int     idx;
        a = longint'(addr);
        exp_err   = !(a >= ORIGIN && a < ORIGIN + MSIZE);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            idx = int'((a - ORIGIN) / 4);
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) ref_mem[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                exp_rdata = ref_mem[d][idx];
            end
        end
    endtask

    task automatic txn(input int d, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        logic        busy_ok;
        logic        stable_ok;
        model(d, wen, addr, wdata, wstrb, exp_rdata, exp_err);
        @(negedge clk);
        sel       = d;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        rsp_ready = 1'b0;
        #1;
        chk("req_ready_idle", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (valid_o) break;
            if (ready_o !== 1'b0) busy_ok = 1'b0;
        end
        chk("latency", 32'(lat), (d == 1) ? 32'd4 : 32'd1);
        chk("req_ready_wait", 32'(busy_ok), 32'd1);
        chk("req_ready_resp", 32'(ready_o), 32'd0);
        chk("rsp_rdata", rdata_o, exp_rdata);
        chk("rsp_err", 32'(err_o), 32'(exp_err));
        stable_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (valid_o !== 1'b1 || rdata_o !== exp_rdata || err_o !== exp_err || ready_o !== 1'b0)
                stable_ok = 1'b0;
        end
        if (hold > 0) chk("resp_stable", 32'(stable_ok), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(valid_o), 32'd0);
        chk("post_rdata", rdata_o, 32'h0);
        chk("post_err", 32'(err_o), 32'd0);
        chk("post_ready", 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] pool [8];
        logic [31:0] dummy_r;
        logic        dummy_e;
        logic [31:0] a;
        checks = 0;
        passes = 0;
        fails  = 0;
        sel       = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        rsp_ready = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) ref_mem[d][i] = 32'h0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready_a", 32'(ready_a), 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd0);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_valid_b", 32'(valid_b), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_err_b", 32'(err_b), 32'd0);
        rst = 1'b1;

        // LATENCY=1 write/read
        txn(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 0);
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);
        // byte strobes
        txn(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 1);
        txn(0, 1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0101, 0);
        txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);
        // LATENCY=4 with response back-pressure
        txn(1, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 3);
        txn(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 3);
        // range boundaries
        txn(0, 1'b1, 32'h8000_0FFC, 32'h5A5A_A5A5, 4'hF, 0);
        txn(0, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0);
        txn(1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1);
        // unaligned read aligns down
        txn(0, 1'b0, 32'h8000_0003, 32'h0, 4'h0, 0);

        // reset while a write is in WAIT
        model(1, 1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, dummy_r, dummy_e);
        @(negedge clk);
        sel       = 1;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0040;
        req_wdata = 32'hCAFE_F00D;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_valid", 32'(valid_b), 32'd0);
        chk("rstmid_ready", 32'(ready_b), 32'd0);
        chk("rstmid_rdata", rdata_b, 32'h0);
        chk("rstmid_err", 32'(err_b), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstrel_ready", 32'(ready_b), 32'd1);
        repeat (5) begin
            @(negedge clk);
            if (valid_b !== 1'b0) break;
        end
        chk("rstrel_no_stale", 32'(valid_b), 32'd0);
        txn(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 0);
        txn(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0);

        // random traffic over a pool of words known in both instances
        pool[0] = 32'h8000_0000; pool[1] = 32'h8000_0004;
        pool[2] = 32'h8000_0010; pool[3] = 32'h8000_0100;
        pool[4] = 32'h8000_07F0; pool[5] = 32'h8000_0FF8;
        pool[6] = 32'h8000_0FFC; pool[7] = 32'h8000_0040;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) txn(d, 1'b1, pool[i], $urandom, 4'hF, 0);
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h8000_1000 + $urandom_range(0, 255);
                    1:       a = 32'h7FFF_FFFC + $urandom_range(0, 3);
                    default: a = $urandom & 32'h7FFF_FFFF;
                endcase
            end else begin
                a = pool[$urandom_range(0, 7)] + $urandom_range(0, 3);
            end
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
